// File: rtl/mem_port_arbiter.sv
// Arbitrates the single unified memory port between instruction fetch and the MEM stage.
// Data accesses have priority. Fetches killed by a flush are drained, not aborted.
module mem_port_arbiter #(
    parameter int AW = 32,
    parameter int DW = 32,
    parameter int CW = 16
) (
    input  logic            clk,
    input  logic            reset,

    input  logic            i_req,
    input  logic [AW-1:0]   i_addr,
    input  logic            i_flush,
    output logic            i_done,
    output logic [DW-1:0]   i_rdata,
    output logic            if_stall,

    input  logic            d_req,
    input  logic            d_we,
    input  logic [AW-1:0]   d_addr,
    input  logic [DW-1:0]   d_wdata,
    input  logic [DW/8-1:0] d_be,
    output logic            d_done,
    output logic [DW-1:0]   d_rdata,
    output logic            d_stall,

    output logic            mem_req,
    output logic            mem_we,
    output logic [AW-1:0]   mem_addr,
    output logic [DW-1:0]   mem_wdata,
    output logic [DW/8-1:0] mem_be,
    input  logic            mem_ack,
    input  logic [DW-1:0]   mem_rdata,

    output logic [CW-1:0]   contention_cnt
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        I_BUSY    = 2'd1,
        D_BUSY    = 2'd2,
        I_DISCARD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [AW-1:0]   mem_addr_q, mem_addr_d;
    logic [DW-1:0]   mem_wdata_q, mem_wdata_d;
    logic [DW/8-1:0] mem_be_q, mem_be_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            contend;

    // A flush landing on the ack cycle still kills the fetch.
    assign i_done   = (state_q == I_BUSY) && mem_ack && !i_flush;
    assign d_done   = (state_q == D_BUSY) && mem_ack;
    assign i_rdata  = mem_rdata;
    assign d_rdata  = mem_rdata;
    assign if_stall = i_req && !i_done;
    assign d_stall  = d_req && !d_done;

    assign mem_req        = mem_req_q;
    assign mem_we         = mem_we_q;
    assign mem_addr       = mem_addr_q;
    assign mem_wdata      = mem_wdata_q;
    assign mem_be         = mem_be_q;
    assign contention_cnt = cnt_q;

    assign contend = i_req && !i_flush &&
                     ((state_q == D_BUSY) || ((state_q == IDLE) && d_req));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_be_d    = mem_be_q;
        cnt_d       = (contend && (cnt_q != {CW{1'b1}})) ? cnt_q + 1'b1 : cnt_q;

        case (state_q)
            IDLE: begin
                if (d_req) begin
                    state_d     = D_BUSY;
                    mem_req_d   = 1'b1;
                    mem_we_d    = d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_wdata;
                    mem_be_d    = d_be;
                end else if (i_req && !i_flush) begin
                    state_d    = I_BUSY;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = i_addr;
                    mem_be_d   = {(DW/8){1'b1}};
                end
            end
            I_BUSY: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end else if (i_flush) begin
                    state_d = I_DISCARD;
                end
            end
            D_BUSY, I_DISCARD: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    mem_req_d = 1'b0;
                end
            end
            default: begin
                state_d   = IDLE;
                mem_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_be_q    <= '0;
            cnt_q       <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_be_q    <= mem_be_d;
            cnt_q       <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and random bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            i_req = 1'b0;
    logic [AW-1:0]   i_addr = '0;
    logic            i_flush = 1'b0;
    logic            i_done;
    logic [DW-1:0]   i_rdata;
    logic            if_stall;
    logic            d_req = 1'b0;
    logic            d_we = 1'b0;
    logic [AW-1:0]   d_addr = '0;
    logic [DW-1:0]   d_wdata = '0;
    logic [DW/8-1:0] d_be = '0;
    logic            d_done;
    logic [DW-1:0]   d_rdata;
    logic            d_stall;
    logic            mem_req;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_wdata;
    logic [DW/8-1:0] mem_be;
    logic            mem_ack = 1'b0;
    logic [DW-1:0]   mem_rdata = '0;
    logic [CW-1:0]   contention_cnt;

    always #5 clk = ~clk;

    mem_port_arbiter #(.AW(AW), .DW(DW), .CW(CW)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_flush(i_flush),
        .i_done(i_done), .i_rdata(i_rdata), .if_stall(if_stall),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
        .d_done(d_done), .d_rdata(d_rdata), .d_stall(d_stall),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .contention_cnt(contention_cnt)
    );

    // Reference model: one outstanding transaction record on the port.
    bit              m_busy = 1'b0;
    bit              m_is_data = 1'b0;
    bit              m_killed = 1'b0;
    bit              m_we = 1'b0;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_wdata = '0;
    logic [DW/8-1:0] m_be = '0;
    int unsigned     m_cnt = 0;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at the negative edge: compare every output against the model.
    task automatic half();
        bit ack_eff, e_ddone, e_idone;
        @(negedge clk);
        ack_eff = m_busy && mem_ack;
        e_ddone = ack_eff && m_is_data;
        e_idone = ack_eff && !m_is_data && !m_killed && !i_flush;
        chk("mem_req",   64'(mem_req),   64'(m_busy));
        chk("mem_we",    64'(mem_we),    64'(m_we));
        chk("mem_addr",  64'(mem_addr),  64'(m_addr));
        chk("mem_wdata", 64'(mem_wdata), 64'(m_wdata));
        chk("mem_be",    64'(mem_be),    64'(m_be));
        chk("i_done",    64'(i_done),    64'(e_idone));
        chk("d_done",    64'(d_done),    64'(e_ddone));
        chk("if_stall",  64'(if_stall),  64'(i_req && !e_idone));
        chk("d_stall",   64'(d_stall),   64'(d_req && !e_ddone));
        chk("cont_cnt",  64'(contention_cnt), 64'(m_cnt));
        if (e_idone) chk("i_rdata", 64'(i_rdata), 64'(mem_rdata));
        if (e_ddone) chk("d_rdata", 64'(d_rdata), 64'(mem_rdata));
    endtask

    // Advance one clock; the model consumes the inputs held during the cycle.
    task automatic adv();
        @(posedge clk);
        if (reset) begin
            m_busy = 0; m_is_data = 0; m_killed = 0; m_we = 0;
            m_addr = '0; m_wdata = '0; m_be = '0; m_cnt = 0;
        end else begin
            if (i_req && !i_flush && ((m_busy && m_is_data) || (!m_busy && d_req))
                && m_cnt < (1 << CW) - 1)
                m_cnt++;
            if (m_busy) begin
                if (!m_is_data && i_flush) m_killed = 1;
                if (mem_ack) m_busy = 0;
            end else if (d_req) begin
                m_busy = 1; m_is_data = 1; m_killed = 0;
                m_we = d_we; m_addr = d_addr; m_wdata = d_wdata; m_be = d_be;
            end else if (i_req && !i_flush) begin
                m_busy = 1; m_is_data = 0; m_killed = 0;
                m_we = 0; m_addr = i_addr; m_be = '1;
            end
        end
        #1;
    endtask

    task automatic cycle();
        half();
        adv();
    endtask

    initial begin
        // Reset
        @(posedge clk);
        #1;
        half();
        chk("rst_mem_req", 64'(mem_req), 64'(0));
        chk("rst_cnt", 64'(contention_cnt), 64'(0));
        adv();
        reset = 1'b0;

        // Single fetch, ack two cycles after mem_req rises
        i_req = 1; i_addr = 32'h100;
        half(); chk("sf_stall0", 64'(if_stall), 64'(1)); adv();
        half(); chk("sf_addr", 64'(mem_addr), 64'h100); chk("sf_we", 64'(mem_we), 64'(0)); adv();
        half(); chk("sf_stall2", 64'(if_stall), 64'(1)); adv();
        mem_ack = 1; mem_rdata = 32'h00500093;
        half(); chk("sf_done", 64'(i_done), 64'(1)); chk("sf_rdata", 64'(i_rdata), 64'h00500093); adv();
        i_req = 0; mem_ack = 0;
        cycle();

        // Simultaneous fetch and load, 1-wait memory
        i_req = 1; i_addr = 32'h104; d_req = 1; d_we = 0; d_addr = 32'h2000;
        cycle();
        half(); chk("sim_daddr", 64'(mem_addr), 64'h2000); adv();
        mem_ack = 1; mem_rdata = 32'h11223344;
        half(); chk("sim_ddone", 64'(d_done), 64'(1)); chk("sim_idone", 64'(i_done), 64'(0)); adv();
        d_req = 0; mem_ack = 0;
        half(); chk("sim_cnt", 64'(contention_cnt), 64'(3)); adv();
        mem_ack = 1; mem_rdata = 32'h00A00113;
        half(); chk("sim_iaddr", 64'(mem_addr), 64'h104); chk("sim_idone2", 64'(i_done), 64'(1)); adv();
        i_req = 0; mem_ack = 0;
        cycle();

        // Store; requester inputs change mid-transaction, latched fields must not
        d_req = 1; d_we = 1; d_addr = 32'h2004; d_wdata = 32'hDEADBEEF; d_be = 4'b0011;
        cycle();
        d_addr = 32'h0; d_wdata = 32'h0; d_be = 4'b1111;
        for (int k = 0; k < 2; k++) begin
            half();
            chk("st_addr", 64'(mem_addr), 64'h2004);
            chk("st_wdata", 64'(mem_wdata), 64'hDEADBEEF);
            chk("st_be", 64'(mem_be), 64'h3);
            chk("st_we", 64'(mem_we), 64'(1));
            adv();
        end
        mem_ack = 1;
        half(); chk("st_done", 64'(d_done), 64'(1)); adv();
        d_req = 0; mem_ack = 0;
        half(); chk("st_done_pulse", 64'(d_done), 64'(0)); adv();

        // Flush one cycle after grant, ack three cycles after the flush
        i_req = 1; i_addr = 32'h200;
        cycle();
        i_flush = 1;
        cycle();
        i_flush = 0; i_req = 0;
        cycle();
        cycle();
        mem_ack = 1; mem_rdata = 32'hBAD0BAD0;
        half(); chk("fl_req", 64'(mem_req), 64'(1)); chk("fl_done", 64'(i_done), 64'(0)); adv();
        mem_ack = 0;
        half(); chk("fl_idle", 64'(mem_req), 64'(0)); adv();

        // Flush coincident with ack, then a fresh fetch
        i_req = 1; i_addr = 32'h300;
        cycle();
        cycle();
        i_flush = 1; mem_ack = 1;
        half(); chk("fa_done", 64'(i_done), 64'(0)); adv();
        i_flush = 0; mem_ack = 0; i_addr = 32'h340;
        cycle();
        mem_ack = 1; mem_rdata = 32'h12345678;
        half(); chk("fa_addr", 64'(mem_addr), 64'h340); chk("fa_done2", 64'(i_done), 64'(1)); adv();
        i_req = 0; mem_ack = 0;
        cycle();

        // Reset in the middle of a data transaction, then a stale ack
        i_req = 1; d_req = 1; d_we = 0; d_addr = 32'h3000;
        cycle();
        cycle();
        reset = 1;
        cycle();
        reset = 0; i_req = 0; d_req = 0;
        half(); chk("rm_req", 64'(mem_req), 64'(0)); chk("rm_cnt", 64'(contention_cnt), 64'(0)); adv();
        mem_ack = 1;
        half(); chk("rm_stale_d", 64'(d_done), 64'(0)); chk("rm_stale_i", 64'(i_done), 64'(0)); adv();
        mem_ack = 0;
        cycle();

        // Counter saturation during a long data transaction
        i_req = 1; d_req = 1; d_addr = 32'h4000;
        for (int k = 0; k < 20; k++) cycle();
        half(); chk("sat_cnt", 64'(contention_cnt), 64'((1 << CW) - 1)); adv();
        i_req = 0; mem_ack = 1;
        cycle();
        d_req = 0; mem_ack = 0;
        cycle();

        // Random traffic
        for (int k = 0; k < 3000; k++) begin
            reset     = ($urandom_range(0, 149) == 0);
            i_req     = ($urandom_range(0, 9) < 7);
            i_flush   = ($urandom_range(0, 9) == 0);
            i_addr    = $urandom;
            d_req     = ($urandom_range(0, 9) < 4);
            d_we      = 1'($urandom);
            d_addr    = $urandom;
            d_wdata   = $urandom;
            d_be      = 4'($urandom);
            mem_ack   = ($urandom_range(0, 99) < 35);
            mem_rdata = $urandom;
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
